// File: rtl/mprj_uart_tx.sv
// Byte-stream UART transmitter: valid/ready byte FIFO feeding an 8N1/8N2 serialiser.
// Optional even-parity bit after the data bits when UART_TX_PARITY_EN is defined.
module mprj_uart_tx #(
  parameter int CLKS_PER_BIT = 4167,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_o,
  output logic                          tx_oeb,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic [7:0]    data;
  logic          frame_done;

  assign full       = (fifo_count == CW'(FIFO_DEPTH));
  assign empty      = (fifo_count == '0);
  assign tx_ready   = !full && !wb_rst_i && !tx_oeb;
  assign push       = tx_valid && tx_ready;
  assign frame_done = (state == ST_STOP) && (timer == '0) && (stop_idx == STOP_LAST);
  assign pop        = !empty && ((state == ST_IDLE) || frame_done);
  assign busy       = (state != ST_IDLE) || !empty;

  // Pad enable releases one edge after reset drops and never reasserts.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) tx_oeb <= 1'b1;
    else          tx_oeb <= 1'b0;
  end

  // NOTE: the storage array has no reset; pointers and count define which entries are valid.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Serialiser: tx_o is registered and updated on each bit boundary.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      data     <= '0;
      tx_o     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            data  <= mem[rd_ptr];
            timer <= BIT_LAST;
            state <= ST_START;
            tx_o  <= 1'b0;
          end
        end
        ST_START: begin
          if (timer == '0) begin
            timer   <= BIT_LAST;
            bit_idx <= '0;
            state   <= ST_DATA;
            tx_o    <= data[0];
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_DATA: begin
          if (timer == '0) begin
            timer <= BIT_LAST;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
              tx_o  <= ^data;
`else
              state    <= ST_STOP;
              stop_idx <= 1'b0;
              tx_o     <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_o    <= data[bit_idx + 3'd1];
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (timer == '0) begin
            timer    <= BIT_LAST;
            state    <= ST_STOP;
            stop_idx <= 1'b0;
            tx_o     <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (timer == '0) begin
            if (stop_idx == STOP_LAST) begin
              if (pop) begin
                // Next byte starts on the same edge so frames abut with no idle gap.
                data  <= mem[rd_ptr];
                timer <= BIT_LAST;
                state <= ST_START;
                tx_o  <= 1'b0;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              stop_idx <= stop_idx + 1'b1;
              timer    <= BIT_LAST;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mprj_uart_tx.sv
// Directed self-checking bench for mprj_uart_tx (CLKS_PER_BIT=8, FIFO_DEPTH=4).
// With UART_TX_PARITY_EN defined it also runs the 8E2 frame case.
module tb_mprj_uart_tx;

  localparam int C = 8;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int STOPS = 2;
  localparam int PAR = 1;
`else
  localparam int STOPS = 1;
  localparam int PAR = 0;
`endif

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_o;
  logic       tx_oeb;
  logic       busy;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;

  mprj_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .STOP_BITS(STOPS)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_o       (tx_o),
    .tx_oeb     (tx_oeb),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at the negedge where the start bit is first visible; returns one
  // negedge past the last stop-bit cycle. Each bit is checked for full width.
  task automatic frame_check(input logic [7:0] b, input string tag);
    logic exp_bits[12];
    int   nb;
    int   cnt;
    nb = 0;
    exp_bits[nb++] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[nb++] = b[i];
    if (PAR != 0) exp_bits[nb++] = ^b;
    for (int i = 0; i < STOPS; i++) exp_bits[nb++] = 1'b1;
    for (int j = 0; j < nb; j++) begin
      cnt = 0;
      for (int c = 0; c < C; c++) begin
        if (tx_o === exp_bits[j]) cnt++;
        @(negedge wb_clk_i);
      end
      check($sformatf("%s_bit%0d", tag, j), cnt, C);
    end
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (tx_o !== 1'b0 && n < 400) begin
      @(negedge wb_clk_i);
      n++;
    end
    check({tag, "_start_seen"}, (n < 400), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge wb_clk_i);
      n++;
    end
    check({tag, "_idle"}, (n < 1000), 1);
  endtask

  int peak;
  int acc;
  int lows;
  int n;

  initial begin
    // 1. Reset behaviour
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk_i);
      if (i > 0) begin
        check("rst_tx_o", tx_o, 1);
        check("rst_oeb", tx_oeb, 1);
        check("rst_ready", tx_ready, 0);
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 0);
      end
    end
    wb_rst_i = 1'b0;
    #1;
    check("rel_ready_before_edge", tx_ready, 0);
    @(negedge wb_clk_i);
    check("rel_oeb", tx_oeb, 0);
    check("rel_ready", tx_ready, 1);
    check("rel_tx_o", tx_o, 1);
    check("rel_count", fifo_count, 0);

    // 2. Single byte 8'h31
    tx_valid = 1'b1;
    tx_data  = 8'h31;
    @(negedge wb_clk_i);
    tx_valid = 1'b0;
    tx_data  = 8'hFF;
    check("single_count_after_push", fifo_count, 1);
    check("single_tx_o_high", tx_o, 1);
    check("single_busy", busy, 1);
    @(negedge wb_clk_i);
    check("single_start_low", tx_o, 0);
    check("single_count_popped", fifo_count, 0);
    frame_check(8'h31, "single");
    check("single_busy_end", busy, 0);
    check("single_tx_o_end", tx_o, 1);

    // 3. Back-to-back 0E, 31, 0A
    repeat (3) @(negedge wb_clk_i);
    tx_valid = 1'b1;
    tx_data  = 8'h0E;
    peak = 0;
    fork
      begin
        @(negedge wb_clk_i);
        tx_data = 8'h31;
        @(negedge wb_clk_i);
        tx_data = 8'h0A;
        @(negedge wb_clk_i);
        tx_valid = 1'b0;
      end
      begin
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        frame_check(8'h0E, "b2b0");
        frame_check(8'h31, "b2b1");
        frame_check(8'h0A, "b2b2");
        check("b2b_busy_end", busy, 0);
      end
      begin
        repeat (260) begin
          @(negedge wb_clk_i);
          if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
      end
    join
    check("b2b_peak", peak, 2);

    // 4. Full FIFO
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    @(negedge wb_clk_i);
    tx_valid = 1'b0;
    @(negedge wb_clk_i);
    check("full_frame_active", tx_o, 0);
    acc = 1;
    tx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tx_data = 8'h40 + 8'(i);
      if (tx_ready) acc++;
      @(negedge wb_clk_i);
    end
    check("full_accepted", acc, 5);
    check("full_count", fifo_count, 4);
    check("full_ready_low", tx_ready, 0);
    n = 0;
    while (fifo_count == 3'd4 && n < 200) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("full_pop_seen", (n < 200), 1);
    check("full_pop_no_push", fifo_count, 3);
    check("full_ready_after_pop", tx_ready, 1);
    tx_valid = 1'b0;
    wait_idle("full");

    // 5. Reset mid-frame: A5 in flight, 11 and 22 queued
    @(negedge wb_clk_i);
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    @(negedge wb_clk_i);
    tx_data = 8'h11;
    @(negedge wb_clk_i);
    check("mid_start_low", tx_o, 0);
    tx_data = 8'h22;
    @(negedge wb_clk_i);
    tx_valid = 1'b0;
    repeat (4 * C + 1) @(negedge wb_clk_i);
    check("mid_bit3", tx_o, 0);
    check("mid_queued", fifo_count, 2);
    wb_rst_i = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h77;
    @(negedge wb_clk_i);
    check("mid_tx_o_high", tx_o, 1);
    check("mid_count_flushed", fifo_count, 0);
    check("mid_busy", busy, 0);
    check("mid_oeb", tx_oeb, 1);
    check("mid_ready", tx_ready, 0);
    @(negedge wb_clk_i);
    check("mid_valid_ignored", fifo_count, 0);
    tx_valid = 1'b0;
    wb_rst_i = 1'b0;
    lows = 0;
    repeat (200) begin
      @(negedge wb_clk_i);
      if (tx_o !== 1'b1) lows++;
    end
    check("mid_no_restart", lows, 0);
    check("mid_idle_busy", busy, 0);

`ifdef UART_TX_PARITY_EN
    // 6. Even parity with two stop bits
    tx_valid = 1'b1;
    tx_data  = 8'h07;
    @(negedge wb_clk_i);
    tx_valid = 1'b0;
    wait_start("par");
    frame_check(8'h07, "par");
    check("par_busy_end", busy, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
